// File: rtl/ks_gadget_recomposer.sv
// rtl/ks_gadget_recomposer.sv - streaming inverse of the keyswitch gadget decomposition
module ks_gadget_recomposer #(
    parameter int KS_L      = 8,
    parameter int KS_B_W    = 2,
    parameter int MOD_KSK_W = 21
) (
    input  logic                 clk,
    input  logic                 a_rst_n,
    input  logic [KS_B_W:0]      in_digit,
    input  logic                 in_last,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [MOD_KSK_W-1:0] out_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 err_last,
    output logic                 err_range
);

    localparam int LVL_W    = (KS_L > 1) ? $clog2(KS_L) : 1;
    localparam int ALIGN_SH = MOD_KSK_W - KS_L * KS_B_W;
    localparam int HALF_B   = 1 << (KS_B_W - 1);
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(KS_L - 1);

    if (KS_L * KS_B_W > MOD_KSK_W) begin : g_bad_params
        $error("ks_gadget_recomposer: KS_L*KS_B_W exceeds MOD_KSK_W");
    end

    // State
    logic [LVL_W-1:0]     lvl_q, lvl_d;
    logic [MOD_KSK_W-1:0] acc_q, acc_d;
    logic [MOD_KSK_W-1:0] out_data_q, out_data_d;
    logic                 out_vld_q, out_vld_d;
    logic                 err_last_q, err_last_d;
    logic                 err_range_q, err_range_d;

    // Datapath helpers
    logic [MOD_KSK_W-1:0] digit_sext;
    logic signed [31:0]   digit_int;
    logic [MOD_KSK_W-1:0] acc_next;
    logic [MOD_KSK_W-1:0] coef_aligned;
    logic                 at_last_lvl;
    logic                 accept;
    logic                 range_bad;

    assign digit_sext   = MOD_KSK_W'($signed(in_digit));
    assign digit_int    = 32'($signed(in_digit));
    assign at_last_lvl  = (lvl_q == LAST_LVL);
    assign acc_next     = (acc_q << KS_B_W) + digit_sext;
    // The final partial sum is shifted up so the first digit lands in the top bits.
    assign coef_aligned = acc_next << ALIGN_SH;
    assign range_bad    = (digit_int < -HALF_B) || (digit_int > HALF_B);

    // Only the final level can be blocked by a stalled output; earlier levels never touch out_*.
    assign in_rdy = ~at_last_lvl | ~out_vld_q | out_rdy;
    assign accept = in_vld & in_rdy;

    // Level counter and accumulator: lvl is authoritative, in_last never resynchronises it.
    always_comb begin
        lvl_d = lvl_q;
        acc_d = acc_q;
        if (accept) begin
            if (at_last_lvl) begin
                lvl_d = '0;
            end else begin
                lvl_d = lvl_q + LVL_W'(1);
            end
            if (lvl_q == '0) begin
                acc_d = digit_sext;
            end else begin
                acc_d = acc_next;
            end
        end
    end

    // Output register: a completion wins over a pop in the same cycle.
    always_comb begin
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        if (accept && at_last_lvl) begin
            out_data_d = coef_aligned;
            out_vld_d  = 1'b1;
        end else if (out_rdy) begin
            out_vld_d  = 1'b0;
        end
    end

    // Error pulses are registered and never stall the datapath.
    always_comb begin
        err_last_d  = accept & (in_last != at_last_lvl);
        err_range_d = accept & range_bad;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            lvl_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            err_last_q  <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            lvl_q       <= lvl_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_vld_q   <= out_vld_d;
            err_last_q  <= err_last_d;
            err_range_q <= err_range_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_vld   = out_vld_q;
    assign err_last  = err_last_q;
    assign err_range = err_range_q;

endmodule

// File: tb/tb_ks_gadget_recomposer.sv
// tb/tb_ks_gadget_recomposer.sv - self-checking bench for ks_gadget_recomposer
`timescale 1ns/1ps
module tb_ks_gadget_recomposer;

    localparam int KS_L      = 8;
    localparam int KS_B_W    = 2;
    localparam int MOD_KSK_W = 21;

    logic                 clk = 1'b0;
    logic                 a_rst_n;
    logic [KS_B_W:0]      in_digit;
    logic                 in_last;
    logic                 in_vld;
    logic                 in_rdy;
    logic [MOD_KSK_W-1:0] out_data;
    logic                 out_vld;
    logic                 out_rdy;
    logic                 err_last;
    logic                 err_range;

    ks_gadget_recomposer #(
        .KS_L(KS_L), .KS_B_W(KS_B_W), .MOD_KSK_W(MOD_KSK_W)
    ) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .in_digit(in_digit), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
        .err_last(err_last), .err_range(err_range)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: digits of the coefficient in flight plus the output slot.
    int                   digits_q[$];
    logic                 m_vld;
    logic [MOD_KSK_W-1:0] m_data;
    logic                 m_err_last;
    logic                 m_err_range;
    int                   n_outputs;

    function automatic logic [MOD_KSK_W-1:0] recompose(input int d[$]);
        longint r = 0;
        for (int j = 0; j < KS_L; j++) begin
            r += longint'(d[j]) * (longint'(1) << (MOD_KSK_W - (j + 1) * KS_B_W));
        end
        return MOD_KSK_W'(r & ((longint'(1) << MOD_KSK_W) - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        digits_q.delete();
        m_vld = 1'b0;
        m_data = '0;
        m_err_last = 1'b0;
        m_err_range = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_vld"},   32'(out_vld),   32'(m_vld));
        check({tag, ".out_data"},  32'(out_data),  32'(m_data));
        check({tag, ".err_last"},  32'(err_last),  32'(m_err_last));
        check({tag, ".err_range"}, 32'(err_range), 32'(m_err_range));
    endtask

    // One clock: drive at negedge, check in_rdy, advance model at posedge, check outputs.
    task automatic cycle(input logic v, input int d, input logic last, input logic ordy,
                         output logic accepted);
        logic exp_rdy;
        logic pop;
        logic done;
        @(negedge clk);
        in_vld = v; in_digit = (KS_B_W + 1)'(d); in_last = last; out_rdy = ordy;
        #1;
        exp_rdy = (digits_q.size() != KS_L - 1) || !m_vld || ordy;
        check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
        accepted = v && exp_rdy;
        @(posedge clk);
        #1;
        m_err_last  = accepted && (last != (digits_q.size() == KS_L - 1));
        m_err_range = accepted && (d < -(1 << (KS_B_W - 1)) || d > (1 << (KS_B_W - 1)));
        pop  = m_vld && ordy;
        done = 1'b0;
        if (accepted) begin
            digits_q.push_back(d);
            if (digits_q.size() == KS_L) begin
                m_data = recompose(digits_q);
                m_vld = 1'b1;
                done = 1'b1;
                n_outputs++;
                digits_q.delete();
            end
        end
        if (pop && !done) m_vld = 1'b0;
        check_outputs("cyc");
    endtask

    // Push one digit, retrying while stalled; a stall longer than the budget is a failure.
    task automatic send_digit(input int d, input logic last, input logic ordy);
        logic acc;
        int tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            cycle(1'b1, d, last, ordy, acc);
            tries++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL send_digit_timeout: observed no accept expected accept within 20 cycles");
        end
    endtask

    task automatic send_coef(input int dg[KS_L], input logic ordy);
        for (int i = 0; i < KS_L; i++) send_digit(dg[i], (i == KS_L - 1), ordy);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, ordy, a);
    endtask

    int   dg[KS_L];
    logic acc_flag;
    int   outs_before;

    initial begin
        n_outputs = 0;
        model_reset();
        a_rst_n = 1'b0; in_vld = 1'b0; in_digit = '0; in_last = 1'b0; out_rdy = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst.out_vld", 32'(out_vld), 32'd0);
        check("rst.out_data", 32'(out_data), 32'd0);
        check("rst.err_last", 32'(err_last), 32'd0);
        check("rst.err_range", 32'(err_range), 32'd0);
        check("rst.in_rdy", 32'(in_rdy), 32'd1);
        a_rst_n = 1'b1;

        // Eight digits of +1
        for (int i = 0; i < KS_L; i++) dg[i] = 1;
        send_coef(dg, 1'b1);
        check("ones.vld", 32'(out_vld), 32'd1);
        check("ones.data", 32'(out_data), 32'h0AAAA0);
        idle(2, 1'b1);

        // -1 then zeros
        for (int i = 0; i < KS_L; i++) dg[i] = 0;
        dg[0] = -1;
        send_coef(dg, 1'b1);
        check("neg1.data", 32'(out_data), 32'h180000);
        dg[0] = 2;
        send_coef(dg, 1'b1);
        check("pos2.data", 32'(out_data), 32'h100000);
        for (int i = 0; i < KS_L; i++) dg[i] = -2;
        send_coef(dg, 1'b1);
        check("neg2.data", 32'(out_data), 32'h0AAAC0);
        idle(1, 1'b1);

        // Back-to-back: four coefficients, continuous, no bubbles
        outs_before = n_outputs;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < KS_L; i++) dg[i] = $urandom_range(4) - 2;
            for (int i = 0; i < KS_L; i++) begin
                cycle(1'b1, dg[i], (i == KS_L - 1), 1'b1, acc_flag);
                check("b2b.accept", 32'(acc_flag), 32'd1);
            end
        end
        check("b2b.count", 32'(n_outputs - outs_before), 32'd4);
        idle(1, 1'b1);

        // Backpressure: hold first output while a second coefficient streams
        for (int i = 0; i < KS_L; i++) dg[i] = $urandom_range(4) - 2;
        send_coef(dg, 1'b0);
        for (int i = 0; i < KS_L; i++) dg[i] = $urandom_range(4) - 2;
        for (int i = 0; i < KS_L - 1; i++) send_digit(dg[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, dg[KS_L-1], 1'b1, 1'b0, acc_flag);
            check("bp.stall", 32'(acc_flag), 32'd0);
        end
        send_digit(dg[KS_L-1], 1'b1, 1'b1);
        idle(2, 1'b1);

        // in_last on the 5th digit; missing in_last on the 8th; out-of-range digit
        for (int i = 0; i < KS_L; i++) send_digit(1, (i == 4), 1'b1);
        for (int i = 0; i < KS_L; i++) send_digit(0, 1'b0, 1'b1);
        send_digit(3, 1'b0, 1'b1);
        for (int i = 1; i < KS_L; i++) send_digit(0, (i == KS_L - 1), 1'b1);
        idle(2, 1'b1);

        // Async reset mid-coefficient with a stalled output pending
        for (int i = 0; i < KS_L; i++) send_digit(1, (i == KS_L - 1), 1'b0);
        for (int i = 0; i < 3; i++) send_digit(-1, 1'b0, 1'b0);
        #3;
        a_rst_n = 1'b0;
        #1;
        check("arst.out_vld", 32'(out_vld), 32'd0);
        check("arst.out_data", 32'(out_data), 32'd0);
        model_reset();
        in_vld = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        for (int i = 0; i < KS_L; i++) dg[i] = 1;
        send_coef(dg, 1'b1);
        check("arst.fresh", 32'(out_data), 32'h0AAAA0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int   d;
            logic v, last, ordy;
            v = ($urandom_range(3) != 0);
            d = ($urandom_range(9) == 0) ? ($urandom_range(1) ? 3 : -3) : ($urandom_range(4) - 2);
            last = (digits_q.size() == KS_L - 1);
            if ($urandom_range(15) == 0) last = ~last;
            ordy = ($urandom_range(2) != 0);
            cycle(v, d, last, ordy, acc_flag);
        end
        idle(3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ks_gadget_recomposer.md
Name: ks_gadget_recomposer

Overview:
- Streaming inverse of the keyswitch gadget decomposition.
- Accepts KS_L signed base-2^KS_B_W digits per coefficient, one digit per cycle, most-significant level first.
- Rebuilds the coefficient modulo 2^MOD_KSK_W.
- Sits on the verification/debug path after the KS decomposer. Used to check decomposition closure and to re-form KSK-domain coefficients for the modulus-switch bench.

Parameters:
- KS_L, 8, number of decomposition levels (digits per coefficient).
- KS_B_W, 2, decomposition base width in bits (B = 2^KS_B_W).
- MOD_KSK_W, 21, output coefficient width; arithmetic is modulo 2^MOD_KSK_W.
- Constraint: KS_L*KS_B_W <= MOD_KSK_W; elaboration error otherwise.

Ports:
- clk  in  1  clock.
- a_rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- in_digit  in  KS_B_W+1  signed two's-complement digit.
- in_last  in  1  sender marks final level (level KS_L-1).
- in_vld  in  1  digit valid.
- in_rdy  out  1  digit accepted when in_vld & in_rdy.
- out_data  out  MOD_KSK_W  recomposed coefficient.
- out_vld  out  1  coefficient valid.
- out_rdy  in  1  downstream accept.
- err_last  out  1  one-cycle pulse: in_last disagrees with internal level count.
- err_range  out  1  one-cycle pulse: accepted digit outside [-B/2, +B/2].

Behaviour:
- Reset (async, a_rst_n=0): lvl=0, acc=0, out_vld=0, out_data=0, err_last=0, err_range=0. Reset mid-coefficient discards partial acc; the next accepted digit is level 0.
- Accumulator:
  - acc is MOD_KSK_W bits.
  - On accept at lvl=0: acc <= sext(in_digit).
  - At lvl>0: acc <= (acc << KS_B_W) + sext(in_digit). Wraps mod 2^MOD_KSK_W.
- Completion at lvl=KS_L-1 accept:
  - out_data <= ((acc << KS_B_W) + sext(in_digit)) << (MOD_KSK_W - KS_L*KS_B_W), truncated to MOD_KSK_W.
  - out_vld <= 1; lvl <= 0.
  - Result equals sum_j d_j * 2^(MOD_KSK_W - (j+1)*KS_B_W) mod 2^MOD_KSK_W, where j=0 is the first digit.
- Level counter: lvl increments per accepted digit and wraps at KS_L-1 -> 0. lvl is authoritative; in_last never resynchronises it.
- Handshake:
  - in_rdy = (lvl != KS_L-1) | ~out_vld | out_rdy. Non-final digits are always accepted, even while an output is stalled.
  - out_vld clears on out_rdy unless a new completion occurs in the same cycle. On simultaneous pop and completion, out_vld stays 1 and out_data takes the new value.
  - out_data/out_vld hold stable while out_vld & ~out_rdy.
- Latency: out_vld asserts the cycle after the final digit is accepted. Throughput is one coefficient per KS_L cycles with no bubbles when out_rdy=1.
- Errors:
  - err_last: on an accepted digit, pulses when in_last != (lvl==KS_L-1).
  - err_range: pulses when in_digit < -B/2 or > B/2. The digit is still accumulated.
  - Both errors are registered (the pulse appears the cycle after the accept) and do not stall the datapath.
- No accept when in_vld=0; state holds.

Test Plan:
- Defaults; 8 digits of +1, in_last on the 8th, out_rdy=1 -> out_data=0x0AAAA0, out_vld 1 cycle after the 8th accept, no errors.
- Digits -1,0,0,0,0,0,0,0 -> out_data=0x180000; digits +2,0,...,0 -> 0x100000; eight digits of -2 -> 0x0AAAC0 (wrap check).
- Back-to-back: 4 coefficients streamed continuously with out_rdy=1 -> 4 outputs spaced exactly 8 cycles apart, in_rdy constantly 1.
- Backpressure: out_rdy=0 while a second coefficient streams -> levels 0..6 accepted, in_rdy=0 at level 7 until out_rdy=1; first out_data held stable, then second delivered; nothing dropped or duplicated.
- in_last on the 5th digit -> err_last pulse one cycle after that accept, no output; a missing in_last on the 8th -> err_last pulse and output still produced. Digit value 3 (B=4) -> err_range pulse, value accumulated as +3.
- Assert a_rst_n low after 3 digits -> out_vld=0 immediately; after release, a fresh 8-digit stream of +1 yields 0x0AAAA0.
